// File: rtl/instruction_fetcher.sv
// Fetch stage: one outstanding 32-bit read at a time, returned words buffered
// with their PC in a small FIFO and delivered to the decoder one per cycle.
module instruction_fetcher #(
    parameter int unsigned QUEUE_WIDTH = 2,
    parameter int unsigned QUEUE_SIZE  = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic [31:0] clear_pc,
    input  logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        to_dec,
    output logic [31:0] to_dec_pc,
    output logic [31:0] to_dec_inst
);

    localparam int unsigned PW = QUEUE_WIDTH;
    localparam int unsigned CW = QUEUE_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic           mem_req_d;
    logic [31:0]    mem_addr_d;
    logic           push, pop;

    logic [31:0]    q_pc   [QUEUE_SIZE];
    logic [31:0]    q_inst [QUEUE_SIZE];
    logic [PW-1:0]  head, tail;
    logic [CW-1:0]  count;

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Next state, request control and FIFO push/pop decisions
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req;
        mem_addr_d = mem_addr;
        push       = 1'b0;
        pop        = !clear && !stall && (count != '0);
        case (state_q)
            IDLE: begin
                if (clear) begin
                    fetch_pc_d = clear_pc;
                end else if (count < CW'(QUEUE_SIZE)) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (clear) begin
                    fetch_pc_d = clear_pc;
                    if (mem_done) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end else if (mem_done) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            DROP: begin
                // The stale read must still complete before a new one may issue
                if (clear) begin
                    fetch_pc_d = clear_pc;
                end
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch PC, memory request and decoder outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fetch_pc_q  <= RESET_PC;
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
            to_dec      <= 1'b0;
            to_dec_pc   <= 32'h0;
            to_dec_inst <= 32'h0;
        end else if (rdy_in) begin
            fetch_pc_q <= fetch_pc_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            to_dec     <= pop;
            if (pop) begin
                to_dec_pc   <= q_pc[head];
                to_dec_inst <= q_inst[head];
            end
        end
    end

    // FIFO pointers and occupancy; clear wins over push and pop
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk_in) begin
        if (rdy_in && push) begin
            q_pc[tail]   <= mem_addr;
            q_inst[tail] <= mem_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: behavioural memory responder,
// expected-PC scoreboard checked on every decoder delivery.
module tb_instruction_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] clear_pc = 32'h0;
    logic        stall = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        to_dec;
    logic [31:0] to_dec_pc;
    logic [31:0] to_dec_inst;

    instruction_fetcher #(
        .QUEUE_WIDTH(2),
        .QUEUE_SIZE (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .clear_pc   (clear_pc),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_done   (mem_done),
        .mem_data   (mem_data),
        .to_dec     (to_dec),
        .to_dec_pc  (to_dec_pc),
        .to_dec_inst(to_dec_inst)
    );

    always #5 clk_in = ~clk_in;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_deliv = 0;
    int          mem_lat = 3;
    int          first_done_cyc = -1;
    int          last_done_cyc = -1;
    logic [31:0] exp_q[$];
    int          deliv_cyc[$];
    logic [31:0] req_addr[$];
    int          req_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: mem_done after mem_lat cycles of an active request
    initial begin : mem_model
        int lat;
        lat = 0;
        forever begin
            @(negedge clk_in);
            #1;
            mem_done = 1'b0;
            if (rst_in) begin
                lat = 0;
            end else if (rdy_in && mem_req === 1'b1) begin
                lat++;
                if (lat >= mem_lat) begin
                    mem_done      = 1'b1;
                    mem_data      = mem_word(mem_addr);
                    lat           = 0;
                    last_done_cyc = cyc;
                    if (first_done_cyc < 0) first_done_cyc = cyc;
                end
            end
        end
    end

    // Output monitor: logs requests, checks each delivery against the scoreboard
    initial begin : monitor
        logic        req_prev;
        logic        rdy_edge;
        logic [31:0] e;
        req_prev = 1'b0;
        forever begin
            @(posedge clk_in);
            cyc++;
            rdy_edge = rdy_in;
            #1;
            if (rst_in) begin
                req_prev = 1'b0;
            end else begin
                if (mem_req === 1'b1 && !req_prev) begin
                    req_addr.push_back(mem_addr);
                    req_cyc.push_back(cyc);
                end
                req_prev = (mem_req === 1'b1);
                if (to_dec === 1'b1 && rdy_edge) begin
                    n_deliv++;
                    deliv_cyc.push_back(cyc);
                    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("to_dec_pc", to_dec_pc, e);
                        check("to_dec_inst", to_dec_inst, mem_word(e));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        clear  = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_to_dec", 32'(to_dec), 32'd0);
        check("rst_to_dec_pc", to_dec_pc, 32'h0);
        check("rst_to_dec_inst", to_dec_inst, 32'h0);
        exp_q.delete();
        deliv_cyc.delete();
        req_addr.delete();
        req_cyc.delete();
        n_deliv        = 0;
        first_done_cyc = -1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic wait_deliv(input int n, input string tag);
        for (int i = 0; i < 3000 && n_deliv < n; i++) @(negedge clk_in);
        check(tag, 32'(n_deliv), 32'(n));
    endtask

    task automatic wait_req(input int n, input string tag);
        for (int i = 0; i < 3000 && req_addr.size() < n; i++) @(negedge clk_in);
        check(tag, 32'(req_addr.size()), 32'(n));
    endtask

    initial begin : stimulus
        int  c_done;
        bit  found;

        // Basic fetch, then clear while waiting on 0x8
        mem_lat = 3;
        stall   = 1'b0;
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h100);
        wait_req(3, "s1_req_count");
        check("s1_req2", req_addr[2], 32'h8);
        clear    = 1'b1;
        clear_pc = 32'h100;
        @(negedge clk_in);
        clear = 1'b0;
        wait_deliv(3, "s1_deliv_count");
        stall = 1'b1;
        check("s1_req0", req_addr[0], 32'h0);
        check("s1_req1", req_addr[1], 32'h4);
        check("s1_req3", req_addr[3], 32'h100);
        check("s1_fill_latency", 32'(deliv_cyc[0] - first_done_cyc), 32'd2);
        check("s1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Stalled fill up to four entries, then drain back-to-back
        stall = 1'b1;
        do_reset();
        repeat (40) @(negedge clk_in);
        check("s2_no_deliv", 32'(n_deliv), 32'd0);
        check("s2_req_count", 32'(req_addr.size()), 32'd4);
        check("s2_req3", req_addr[3], 32'hC);
        check("s2_mem_req_idle", 32'(mem_req), 32'd0);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
        stall = 1'b0;
        wait_deliv(5, "s2_deliv_count");
        stall = 1'b1;
        check("s2_back_to_back", 32'(deliv_cyc[3] - deliv_cyc[0]), 32'd3);
        check("s2_resume_addr", req_addr[4], 32'h10);
        check("s2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Clear coincident with mem_done for 0x4
        stall = 1'b0;
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h40);
        found  = 1'b0;
        c_done = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk_in);
            #2;
            if (mem_done && mem_addr == 32'h4) found = 1'b1;
        end
        check("s3_done_seen", 32'(found), 32'd1);
        c_done   = last_done_cyc;
        clear    = 1'b1;
        clear_pc = 32'h40;
        @(negedge clk_in);
        clear = 1'b0;
        wait_deliv(2, "s3_deliv_count");
        stall = 1'b1;
        check("s3_redirect_addr", req_addr[2], 32'h40);
        check("s3_redirect_delay", 32'(req_cyc[2] - c_done), 32'd2);
        check("s3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Two clears while draining a slow read
        mem_lat = 8;
        stall   = 1'b0;
        do_reset();
        exp_q.push_back(32'h300);
        wait_req(1, "s4_req_count");
        clear    = 1'b1;
        clear_pc = 32'h200;
        @(negedge clk_in);
        clear_pc = 32'h300;
        @(negedge clk_in);
        clear = 1'b0;
        check("s4_drop_req_held", 32'(mem_req), 32'd1);
        check("s4_drop_addr_held", mem_addr, 32'h0);
        wait_deliv(1, "s4_deliv_count");
        stall = 1'b1;
        check("s4_redirect_addr", req_addr[1], 32'h300);
        check("s4_sb_empty", 32'(exp_q.size()), 32'd0);

        // rdy_in low mid-WAIT with two buffered entries
        mem_lat = 3;
        stall   = 1'b1;
        do_reset();
        wait_req(3, "s5_req_count");
        rdy_in = 1'b0;
        repeat (5) begin
            @(negedge clk_in);
            check("s5_frz_mem_req", 32'(mem_req), 32'd1);
            check("s5_frz_mem_addr", mem_addr, 32'h8);
            check("s5_frz_to_dec", 32'(to_dec), 32'd0);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        rdy_in = 1'b1;
        stall  = 1'b0;
        wait_deliv(4, "s5_deliv_count");
        stall = 1'b1;
        check("s5_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset while fetching continues in the background
        repeat (3) @(negedge clk_in);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
